// File: rtl/stack_push_seq_pkg.sv
// Shared CPU definitions for the stack push sequencer:
// push-mode codes, FSM state encoding and processor-status bit indices.
package stack_push_seq_pkg;

    // Push types carried on the 3-bit mode input
    localparam logic [2:0] PUSH_PHA = 3'b000;
    localparam logic [2:0] PUSH_PHP = 3'b001;
    localparam logic [2:0] PUSH_JSR = 3'b010;
    localparam logic [2:0] PUSH_BRK = 3'b011;
    localparam logic [2:0] PUSH_IRQ = 3'b100;
    localparam logic [2:0] PUSH_NMI = 3'b101;

    // P register bit positions
    localparam int unsigned FLAG_B = 4;
    localparam int unsigned FLAG_U = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PUSH_H = 2'd1,
        ST_PUSH_L = 2'd2,
        ST_PUSH_P = 2'd3
    } state_t;

    // Modes 110/111 are reserved and never start a sequence
    function automatic logic mode_valid(input logic [2:0] m);
        return m <= PUSH_NMI;
    endfunction

endpackage

// File: rtl/stack_push_seq_byte_sel.sv
// push_byte_sel: combinational byte selector for the stack push sequencer.
// Ports:
//   state      in   current sequencer state
//   mode       in   latched push type
//   acc        in   latched accumulator
//   flags      in   latched processor status
//   pcl, pch   in   latched return-address bytes
//   data_write out  byte to place on the write bus (0 in IDLE)
module push_byte_sel
    import stack_push_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  state_t              state,
    input  logic [2:0]          mode,
    input  logic [DATA_W-1:0]   acc,
    input  logic [DATA_W-1:0]   flags,
    input  logic [DATA_W-1:0]   pcl,
    input  logic [DATA_W-1:0]   pch,
    output logic [DATA_W-1:0]   data_write
);

    logic [DATA_W-1:0] p_byte;

    // Pushed P: U always set, B set only for software pushes (PHP/BRK)
    always_comb begin
        p_byte         = flags;
        p_byte[FLAG_U] = 1'b1;
        p_byte[FLAG_B] = (mode == PUSH_PHP) || (mode == PUSH_BRK);
    end

    always_comb begin
        data_write = '0;
        case (state)
            ST_PUSH_H: data_write = pch;
            ST_PUSH_L: data_write = pcl;
            ST_PUSH_P: data_write = (mode == PUSH_PHA) ? acc : p_byte;
            default:   data_write = '0;
        endcase
    end

endmodule

// File: rtl/stack_push_seq.sv
// stack_push_seq: multi-cycle stack write sequencer for PHA/PHP/JSR/BRK/IRQ/NMI.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, mode         one-cycle request and push type (sampled in IDLE)
//   acc, flags, pcl,
//   pch, sp_in          operands, latched on an accepted start
//   rdy                 memory ready; low stalls the current byte
//   data_write, addr,
//   we                  stack write bus
//   sp_out              live stack pointer
//   busy, done          sequence active / final byte accepted (done follows rdy)
module stack_push_seq
    import stack_push_seq_pkg::*;
#(
    parameter int unsigned      DATA_W     = 8,
    parameter int unsigned      ADDR_W     = 16,
    parameter logic [DATA_W-1:0] STACK_PAGE = DATA_W'(1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          mode,
    input  logic [DATA_W-1:0]   acc,
    input  logic [DATA_W-1:0]   flags,
    input  logic [DATA_W-1:0]   pcl,
    input  logic [DATA_W-1:0]   pch,
    input  logic [DATA_W-1:0]   sp_in,
    input  logic                rdy,
    output logic [DATA_W-1:0]   data_write,
    output logic [ADDR_W-1:0]   addr,
    output logic                we,
    output logic [DATA_W-1:0]   sp_out,
    output logic                busy,
    output logic                done
);

    state_t            state_q, state_d;
    logic [2:0]        mode_q;
    logic [DATA_W-1:0] acc_q, flags_q, pcl_q, pch_q, sp_q;
    logic              launch;
    logic              accept;

    assign launch = (state_q == ST_IDLE) && start && mode_valid(mode);

    // State register, operand latches and stack pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            acc_q   <= '0;
            flags_q <= '0;
            pcl_q   <= '0;
            pch_q   <= '0;
            sp_q    <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                mode_q  <= mode;
                acc_q   <= acc;
                flags_q <= flags;
                pcl_q   <= pcl;
                pch_q   <= pch;
                sp_q    <= sp_in;
            end else if (accept) begin
                sp_q <= sp_q - DATA_W'(1);
            end
        end
    end

    // Next-state and write-control decode
    always_comb begin
        state_d = state_q;
        we      = 1'b0;
        busy    = 1'b0;
        accept  = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ((mode == PUSH_PHA) || (mode == PUSH_PHP)) ? ST_PUSH_P : ST_PUSH_H;
                end
            end
            ST_PUSH_H: begin
                we     = 1'b1;
                busy   = 1'b1;
                accept = rdy;
                if (rdy) state_d = ST_PUSH_L;
            end
            ST_PUSH_L: begin
                we     = 1'b1;
                busy   = 1'b1;
                accept = rdy;
                // JSR ends after the low return-address byte
                if (rdy) begin
                    if (mode_q == PUSH_JSR) begin
                        state_d = ST_IDLE;
                        done    = 1'b1;
                    end else begin
                        state_d = ST_PUSH_P;
                    end
                end
            end
            ST_PUSH_P: begin
                we     = 1'b1;
                busy   = 1'b1;
                accept = rdy;
                if (rdy) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    push_byte_sel #(
        .DATA_W (DATA_W)
    ) u_byte_sel (
        .state      (state_q),
        .mode       (mode_q),
        .acc        (acc_q),
        .flags      (flags_q),
        .pcl        (pcl_q),
        .pch        (pch_q),
        .data_write (data_write)
    );

    assign addr   = ADDR_W'({STACK_PAGE, sp_q});
    assign sp_out = sp_q;

endmodule

// File: tb/tb_stack_push_seq.sv
// Directed, table-driven bench for stack_push_seq.
module tb_stack_push_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  mode;
    logic [7:0]  acc, flags, pcl, pch, sp_in;
    logic        rdy;
    logic [7:0]  data_write;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  sp_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_push_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .acc        (acc),
        .flags      (flags),
        .pcl        (pcl),
        .pch        (pch),
        .sp_in      (sp_in),
        .rdy        (rdy),
        .data_write (data_write),
        .addr       (addr),
        .we         (we),
        .sp_out     (sp_out),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [2:0]       mode;
        logic [7:0]       acc;
        logic [7:0]       flags;
        logic [7:0]       pcl;
        logic [7:0]       pch;
        logic [7:0]       sp;
        int               n;
        logic [2:0][7:0]  b;
        logic [2:0][15:0] a;
        logic [7:0]       sp_end;
    } vec_t;

    function automatic vec_t mkv(logic [2:0] m, logic [7:0] acc_v, logic [7:0] flags_v,
                                 logic [7:0] pcl_v, logic [7:0] pch_v, logic [7:0] sp_v,
                                 int n_v, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                                 logic [15:0] a0, logic [15:0] a1, logic [15:0] a2,
                                 logic [7:0] spe);
        vec_t v;
        v.mode = m; v.acc = acc_v; v.flags = flags_v; v.pcl = pcl_v; v.pch = pch_v;
        v.sp = sp_v; v.n = n_v;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
        v.sp_end = spe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] sp_exp);
        #2;
        chk({tag, " idle we"},   32'(we), 32'd0);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        chk({tag, " idle done"}, 32'(done), 32'd0);
        chk({tag, " idle sp"},   32'(sp_out), 32'(sp_exp));
        chk({tag, " idle addr"}, 32'(addr), 32'(16'h0100 | 16'(sp_exp)));
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] b, input logic [15:0] a,
                            input logic dn);
        #2;
        chk({tag, " we"},   32'(we), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " data"}, 32'(data_write), 32'(b));
        chk({tag, " addr"}, 32'(addr), 32'(a));
        chk({tag, " done"}, 32'(done), 32'(dn));
    endtask

    task automatic launch(input logic [2:0] m, input logic [7:0] a, input logic [7:0] f,
                          input logic [7:0] l, input logic [7:0] h, input logic [7:0] s);
        mode = m; acc = a; flags = f; pcl = l; pch = h; sp_in = s; start = 1'b1;
        step();
        // Scramble operands: only the latched copies may matter
        start = 1'b0;
        acc = ~a; flags = ~f; pcl = ~l; pch = ~h; sp_in = ~s; mode = 3'b110;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = mkv(3'd0, 8'h5A, 8'h00, 8'h00, 8'h00, 8'hFD, 1,
                      8'h5A, 8'h00, 8'h00, 16'h01FD, 16'h0000, 16'h0000, 8'hFC);
        vecs[1] = mkv(3'd3, 8'h00, 8'h81, 8'h34, 8'h12, 8'hFF, 3,
                      8'h12, 8'h34, 8'hB1, 16'h01FF, 16'h01FE, 16'h01FD, 8'hFC);
        vecs[2] = mkv(3'd4, 8'h00, 8'h30, 8'hCD, 8'hAB, 8'h01, 3,
                      8'hAB, 8'hCD, 8'h20, 16'h0101, 16'h0100, 16'h01FF, 8'hFE);
        vecs[3] = mkv(3'd1, 8'h77, 8'h00, 8'h00, 8'h00, 8'h80, 1,
                      8'h30, 8'h00, 8'h00, 16'h0180, 16'h0000, 16'h0000, 8'h7F);
        vecs[4] = mkv(3'd2, 8'h00, 8'h00, 8'h02, 8'h80, 8'h00, 2,
                      8'h80, 8'h02, 8'h00, 16'h0100, 16'h01FF, 16'h0000, 8'hFE);
        vecs[5] = mkv(3'd5, 8'h00, 8'hFF, 8'h22, 8'h11, 8'h10, 3,
                      8'h11, 8'h22, 8'hEF, 16'h0110, 16'h010F, 16'h010E, 8'h0D);
        vecs[6] = mkv(3'd1, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h05, 1,
                      8'h3F, 8'h00, 8'h00, 16'h0105, 16'h0000, 16'h0000, 8'h04);

        rst_n = 1'b0; start = 1'b0; mode = '0; acc = '0; flags = '0;
        pcl = '0; pch = '0; sp_in = '0; rdy = 1'b1;
        step();
        step();
        #2;
        chk("reset data", 32'(data_write), 32'd0);
        chk_idle("reset", 8'h00);
        rst_n = 1'b1;
        step();

        // Table: full sequences with rdy held high
        for (int v = 0; v < 7; v++) begin
            launch(vecs[v].mode, vecs[v].acc, vecs[v].flags, vecs[v].pcl,
                   vecs[v].pch, vecs[v].sp);
            for (int i = 0; i < vecs[v].n; i++) begin
                chk_byte($sformatf("vec%0d byte%0d", v, i), vecs[v].b[i], vecs[v].a[i],
                         (i == vecs[v].n - 1));
                step();
            end
            chk_idle($sformatf("vec%0d", v), vecs[v].sp_end);
        end

        // JSR with rdy low for three cycles during the low byte
        launch(3'd2, 8'h00, 8'h00, 8'hBC, 8'h9A, 8'hFF);
        chk_byte("jsr H", 8'h9A, 16'h01FF, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            rdy = 1'b0;
            chk_byte($sformatf("jsr stall%0d", k), 8'hBC, 16'h01FE, 1'b0);
            chk($sformatf("jsr stall%0d sp", k), 32'(sp_out), 32'h0FE);
            step();
        end
        rdy = 1'b1;
        chk_byte("jsr L accept", 8'hBC, 16'h01FE, 1'b1);
        step();
        chk_idle("jsr", 8'hFD);

        // Reserved mode while idle is ignored
        mode = 3'b111; start = 1'b1; acc = 8'h99; sp_in = 8'h55;
        step();
        start = 1'b0;
        chk_idle("reserved", 8'hFD);
        step();
        chk_idle("reserved2", 8'hFD);

        // start during BRK is ignored
        launch(3'd3, 8'h00, 8'h00, 8'h02, 8'h01, 8'h40);
        mode = 3'd0; acc = 8'hEE; sp_in = 8'h90; start = 1'b1;
        chk_byte("brk H", 8'h01, 16'h0140, 1'b0);
        step();
        chk_byte("brk L", 8'h02, 16'h013F, 1'b0);
        step();
        start = 1'b0;
        chk_byte("brk P", 8'h30, 16'h013E, 1'b1);
        step();
        chk_idle("brk", 8'h3D);
        step();
        chk_idle("brk quiet", 8'h3D);

        // Reset during the low byte of NMI aborts the sequence
        launch(3'd5, 8'h00, 8'h00, 8'h66, 8'h55, 8'h20);
        chk_byte("nmi H", 8'h55, 16'h0120, 1'b0);
        step();
        chk_byte("nmi L", 8'h66, 16'h011F, 1'b0);
        rst_n = 1'b0;
        step();
        chk("nmi rst data", 32'(data_write), 32'd0);
        chk_idle("nmi rst", 8'h00);
        rst_n = 1'b1;
        step();
        chk_idle("nmi post1", 8'h00);
        step();
        chk_idle("nmi post2", 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
